// File: rtl/signed_seq_div.sv
// Sequential signed divider: sign-magnitude wrapper around an unsigned restoring core.
// 2*DW-bit dividend / DW-bit divisor -> 2*DW-bit quotient (toward zero) + DW-bit remainder.
module signed_seq_div #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero,
  output logic            overflow
);

  localparam int QW = 2*DW;
  localparam int CW = $clog2(QW+1);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DW:0]     pr;
  logic [QW-1:0]   qsh;     // dividend magnitude shifts out MSB-first, quotient bits shift in
  logic [DW-1:0]   dvs;
  logic            neg_q, neg_r;

  logic            accept, is_zero, is_ovf, last_it, q_bit;
  logic [DW:0]     pr_sh, pr_sub;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_zero  = (divisor == '0);
  assign is_ovf   = (dividend == {1'b1, {(QW-1){1'b0}}}) && (divisor == '1);
  assign last_it  = (cnt == CW'(QW-1));

  always_comb begin
    pr_sh  = {pr[DW-1:0], qsh[QW-1]};
    pr_sub = pr_sh - {1'b0, dvs};
    q_bit  = (pr_sh >= {1'b0, dvs});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = (is_zero || is_ovf) ? DONE : DIV;
      DIV:  if (last_it)   state_nxt = FIX;
      FIX:                 state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pr        <= '0;
      qsh       <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          neg_q <= dividend[QW-1] ^ divisor[DW-1];
          neg_r <= dividend[QW-1];
          // -(-2^(QW-1)) wraps back to 2^(QW-1), which is the correct unsigned magnitude
          qsh   <= dividend[QW-1] ? -dividend : dividend;
          dvs   <= divisor[DW-1]  ? -divisor  : divisor;
          cnt   <= '0;
          pr    <= '0;
          if (is_zero) begin
            out_valid <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
          end else if (is_ovf) begin
            out_valid <= 1'b1;
            quotient  <= dividend;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b1;
          end
        end
        DIV: begin
          pr  <= q_bit ? pr_sub : pr_sh;
          qsh <= {qsh[QW-2:0], q_bit};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          // negating a zero remainder yields zero, so +0 is reported naturally
          quotient  <= neg_q ? -qsh : qsh;
          remainder <= DW'(neg_r ? -pr : pr);
          div_zero  <= 1'b0;
          overflow  <= 1'b0;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_div.sv
// Scoreboard bench for signed_seq_div: driver pushes expected results, monitor pops on output.
module tb_signed_seq_div;
  localparam int DW = 8;
  localparam int QW = 2*DW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [QW-1:0] dividend = '0, quotient;
  logic [DW-1:0] divisor = '0, remainder;
  logic          out_valid, out_ready = 1'b1, div_zero, overflow;

  typedef struct {
    logic [QW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ov;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;

  signed_seq_div #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every cycle the result is presented, latency on the first one
  always @(negedge clk) begin : mon
    exp_t e;
    logic seen;
    if (!rst_n) seen = 1'b0;
    else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got q=%0h r=%0h with no pending operation", quotient, remainder);
      end else begin
        e = sb[0];
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("overflow", 32'(overflow), 32'(e.ov));
        if (!seen) chk("latency", cyc - e.acc, e.lat);
        else       chk("busy_in_ready", 32'(in_ready), 32'(0));
        seen = 1'b1;
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accept edge
  task automatic issue(logic [QW-1:0] a, logic [DW-1:0] b, logic [QW-1:0] eq,
                       logic [DW-1:0] er, logic edz, logic eov, int elat);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk);
    e = '{q:eq, r:er, dz:edz, ov:eov, lat:elat, acc:cyc};
    sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_flags", {30'd0, div_zero, overflow}, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'd100,    8'd7,     16'h000E, 8'h02, 0, 0, 18); wait_done();
    issue(-16'sd100,  8'd7,     16'hFFF2, 8'hFE, 0, 0, 18); wait_done();
    issue(16'd100,    -8'sd7,   16'hFFF2, 8'h02, 0, 0, 18); wait_done();
    issue(-16'sd100,  -8'sd7,   16'h000E, 8'hFE, 0, 0, 18); wait_done();
    issue(16'h8000,   8'hFF,    16'h8000, 8'h00, 0, 1, 1);  wait_done();
    issue(16'd1234,   8'd0,     16'hFFFF, 8'h00, 1, 0, 1);  wait_done();

    // Backpressure: result must hold while stalled, busy-time in_valid ignored
    out_ready = 1'b0;
    issue(16'd100, 8'd7, 16'h000E, 8'h02, 0, 0, 18);
    for (int n = 0; n < 40 && !out_valid; n++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      dividend = 16'd5; divisor = 8'd1; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_done();
    repeat (3) @(posedge clk); #1;
    chk("no_extra_valid", 32'(out_valid), 0);
    chk("idle_in_ready", 32'(in_ready), 1);

    // Reset during the 9th DIV cycle
    dividend = 16'd100; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 chk("mid_div_busy", 32'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_quotient", 32'(quotient), 0);
    chk("arst_remainder", 32'(remainder), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'd32767, 8'd1, 16'h7FFF, 8'h00, 0, 0, 18); wait_done();

    issue(16'h8000,  8'd1,    16'h8000, 8'h00, 0, 0, 18); wait_done();
    issue(16'h8000,  8'h80,   16'h0100, 8'h00, 0, 0, 18); wait_done();
    issue(16'd127,   8'h80,   16'h0000, 8'h7F, 0, 0, 18); wait_done();
    issue(16'hFFFF,  8'd2,    16'h0000, 8'hFF, 0, 0, 18); wait_done();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
